seq_multiplier_32bit: RTL and testbench
=======================================

Name: seq_multiplier_32bit

Overview:
Multi-cycle unsigned 32x32 -> 64-bit shift-add multiplier for the week06 ALU datapath. It sits directly downstream of ripple_carry_adder_32bit: it instantiates one adder and feeds it the partial-product upper half and the multiplicand every cycle. Then it consumes the adder's sum and carry-out to build the product over 32 iterations. It exposes a start/busy/done handshake so the ALU control can issue MUL operations.

Parameters:
- N, 32, operand width. Only 32 is supported because the adder is fixed at 32 bits.
- CNT_W, 5, iteration counter width. Local constant, not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled on rising clk
- a  input  32  multiplicand; sampled only when start is accepted
- b  input  32  multiplier; sampled only when start is accepted
- busy  output  1  high while iterating (RUN state)
- done  output  1  one-cycle pulse, high in the DONE state
- product  output  64  result register; holds the last completed product

Behaviour:
- Reset: asynchronous and active-high. While reset is high:
  - state = IDLE, counter = 0
  - internal M, P and product = 0
  - busy = 0, done = 0
- States are IDLE, RUN and DONE.
  - busy = (state == RUN).
  - done = (state == DONE).
  - Both are decoded directly from the registered state.
- Start acceptance: start is accepted only in IDLE or DONE. On an accepting edge:
  - M <= a
  - P <= {32'h0, b}
  - counter <= 0
  - state <= RUN
- Start is ignored while in RUN. Operands and the in-flight operation are unaffected.
- Adder hookup, driven combinationally every cycle:
  - adder a = P[63:32]
  - adder b = P[0] ? M : 32'h0
  - adder c_in = 0
- RUN, each edge:
  - P <= {c_out, sum, P[31:1]}. This is a 65-bit value shifted right by one, so the result is 64 bits.
  - counter <= counter + 1.
  - When counter == 31 on this edge: product <= the new P value (the same value being loaded into P), and state <= DONE.
- Latency: if start is accepted at edge k, the 32 iterations occur at edges k+1..k+32. done and the new product are visible after edge k+32.
- DONE lasts exactly one cycle. Next edge: to RUN if start is high (back-to-back, new operands latched), otherwise to IDLE.
- product changes only at completion or reset. It is stable during RUN, IDLE and DONE.
- Arithmetic: unsigned only. The full 64-bit result is exact, so there is no overflow. The carry-out of each add is preserved in the shift and never dropped.
- Boundary cases:
  - a = 0 or b = 0 still takes the full 32 cycles; there is no early termination.
  - The counter does not wrap in RUN; exit happens at 31.
  - A mid-operation reset aborts the operation, clears product to 0, and no done is produced.
- No X propagation: M and P are registered and reset, so the adder inputs are always defined.

Decomposition:
- Shared package / header (alu_defs): state encoding constants S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, the MUL ALU opcode, and the iteration count constant 32.
- Sub-module: exactly one instance of the existing ripple_carry_adder_32bit (port names a, b, c_in, sum, c_out).
- FSM, counter and P/M registers live in the top module. No further hierarchy is needed.

Test Plan:
1. Reset, then start with a = 3, b = 5 → busy for 32 cycles, done after edge k+32, product = 64'h0000_0000_0000_000F.
2. a = 32'hFFFF_FFFF, b = 32'hFFFF_FFFF → product = 64'hFFFF_FFFE_0000_0001. Checks c_out propagation into P[63].
3. a = 32'h1234_5678, b = 0, then a = 0, b = 32'hDEAD_BEEF → both take 32 cycles, product = 0, done pulses exactly once per operation.
4. Start a = 7, b = 6; pulse start with a = 9, b = 9 at cycle 10 of RUN → pulse ignored, product = 42, done at the original edge.
5. Start held high continuously with a = 2, b = 3, then a = 4, b = 5 changed in the DONE cycle → products 6 then 20, the second done 33 cycles after the first, and IDLE never entered.
6. Start a = 32'h8000_0000, b = 2; assert reset at RUN cycle 16 → busy = 0, done = 0, product = 0 immediately (asynchronous). After reset, a fresh run gives product = 64'h0000_0001_0000_0000.

Source files
------------

// File: rtl/seq_multiplier_32bit_pkg.sv
// ---------------------------------------------------------------------------
// seq_multiplier_32bit_pkg
// Shared ALU definitions used by the sequential multiplier:
//   - multiplier FSM state encoding (IDLE / RUN / DONE)
//   - ALU opcode that selects the multiply operation
//   - number of shift-add iterations per multiply
// No ports (package).
// ---------------------------------------------------------------------------
package seq_multiplier_32bit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

    localparam logic [3:0] ALU_OP_MUL = 4'h5;

    localparam int ITER_COUNT = 32;

endpackage : seq_multiplier_32bit_pkg

// File: rtl/seq_multiplier_32bit_adder.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder_32bit
// Purely combinational 32-bit ripple-carry adder.
// Ports:
//   a, b   [31:0] in  : addends
//   c_in          in  : carry into bit 0
//   sum    [31:0] out : a + b + c_in (low 32 bits)
//   c_out         out : carry out of bit 31
// ---------------------------------------------------------------------------
module ripple_carry_adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    logic carry;

    // Carry is walked bit by bit in a variable so the chain stays a single
    // combinational path without a self-referencing vector.
    always_comb begin
        sum   = '0;
        carry = c_in;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule : ripple_carry_adder_32bit

// File: rtl/seq_multiplier_32bit.sv
// ---------------------------------------------------------------------------
// seq_multiplier_32bit
// Unsigned 32x32 -> 64 shift-add multiplier, one iteration per clock,
// 32 iterations per product, built around one ripple-carry adder.
// Ports:
//   clk            in  : rising-edge clock
//   reset          in  : asynchronous, active-high reset
//   start          in  : multiply request, accepted in IDLE or DONE
//   a      [31:0]  in  : multiplicand, latched on accepted start
//   b      [31:0]  in  : multiplier, latched on accepted start
//   busy           out : high while iterating
//   done           out : one-cycle completion pulse
//   product[63:0]  out : last completed product
// ---------------------------------------------------------------------------
module seq_multiplier_32bit
    import seq_multiplier_32bit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     m_q, m_d;
    logic [2*N-1:0]   p_q, p_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [N-1:0]     add_b;
    logic [N-1:0]     add_sum;
    logic             add_cout;
    logic [2*N-1:0]   p_shift;

    // Add the multiplicand into the upper half only when the current
    // multiplier bit (P[0]) is set.
    assign add_b = p_q[0] ? m_q : '0;

    ripple_carry_adder_32bit u_adder (
        .a     (p_q[2*N-1:N]),
        .b     (add_b),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // 65-bit {c_out, sum, P_low} shifted right by one: the carry lands in
    // bit 63 and the consumed multiplier bit falls off the bottom.
    assign p_shift = {add_cout, add_sum, p_q[N-1:1]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        p_d       = p_q;
        product_d = product_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    m_d     = a;
                    p_d     = {{N{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                p_d   = p_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    product_d = p_shift;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            m_q       <= '0;
            p_q       <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            p_q       <= p_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule : seq_multiplier_32bit

// File: tb/tb_seq_multiplier_32bit.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier_32bit
// Self-checking bench for seq_multiplier_32bit: directed scenarios plus
// randomized operands compared against a plain-arithmetic reference.
// ---------------------------------------------------------------------------
module tb_seq_multiplier_32bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int errors = 0;
    int checks = 0;

    seq_multiplier_32bit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        return {32'h0, x} * {32'h0, y};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    // Counts rising edges (sampled #1 after each) until done is seen.
    // Also reports whether an idle cycle (neither busy nor done) or a
    // product change occurred along the way.
    task automatic wait_done(output int n, output bit idle_seen, output bit prod_moved);
        logic [63:0] prev;
        prev       = product;
        n          = 0;
        idle_seen  = 1'b0;
        prod_moved = 1'b0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (!busy) idle_seen = 1'b1;
            if (product !== prev) prod_moved = 1'b1;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v);
        int n;
        bit idle_seen, moved;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
        wait_done(n, idle_seen, moved);
        chk({tag, " latency"}, 64'(n), 64'd32);
        chk({tag, " product"}, product, ref_mul(ta, tb_v));
        chk({tag, " stable_in_run"}, 64'({idle_seen, moved}), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, " done_single_pulse"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int  n, n2;
        bit  idle_seen, moved;
        logic [31:0] ra, rb;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset product", product, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("t1 3x5", 32'd3, 32'd5);
        run_op("t2 max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("t3 b0", 32'h1234_5678, 32'h0);
        run_op("t3 a0", 32'h0, 32'hDEAD_BEEF);

        // Start pulse in the middle of a run must be ignored.
        @(negedge clk);
        a = 32'd7; b = 32'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, idle_seen, moved);
        chk("t4 latency", 64'(n + 10), 64'd32);
        chk("t4 product", product, 64'd42);

        // Back-to-back with start held high.
        @(negedge clk);
        a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(n, idle_seen, moved);
        chk("t5 first latency", 64'(n), 64'd32);
        chk("t5 first product", product, 64'd6);
        a = 32'd4; b = 32'd5;
        wait_done(n2, idle_seen, moved);
        chk("t5 done spacing", 64'(n2), 64'd33);
        chk("t5 second product", product, 64'd20);
        chk("t5 no idle", 64'(idle_seen), 64'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("t5 idle after", 64'({busy, done}), 64'd0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        a = 32'h8000_0000; b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t6 reset busy", 64'(busy), 64'd0);
        chk("t6 reset done", 64'(done), 64'd0);
        chk("t6 reset product", product, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("t6 rerun", 32'h8000_0000, 32'd2);
        chk("t6 rerun value", product, 64'h0000_0001_0000_0000);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'hFFFF_FFFF;
            if (i == 1) rb = 32'h8000_0001;
            run_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_multiplier_32bit
